// File: rtl/updown_bcd_counter_pkg.sv
// Shared types, constants and BCD digit arithmetic for the four-digit up/down BCD counter.
package updown_bcd_counter_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         DEF_SYS_CLK_HZ = 100_000_000;
    localparam int         DEF_TICK_HZ    = 10;

    // One digit step: returns {carry/borrow out, new digit}; an out-of-range digit counts as 0.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit,
                                            input logic       down,
                                            input logic       cin);
        logic [3:0] d;
        logic [4:0] r;
        d = (digit > BCD_MAX) ? 4'd0 : digit;
        r = {1'b0, d};
        if (cin) begin
            if (down) begin
                if (d == 4'd0) r = {1'b1, BCD_MAX};
                else           r = {1'b0, d - 4'd1};
            end else begin
                if (d == BCD_MAX) r = {1'b1, 4'd0};
                else              r = {1'b0, d + 4'd1};
            end
        end else begin
            r = {1'b0, d};
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_bcd_counter_tick_gen.sv
// Clock divider producing a one-cycle tick every TICK_DIV enabled cycles; cleared while disabled.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;

    // The stale terminal value left behind on disable must not fire a tick.
    assign o_tick = i_en && (div_q == LAST);

    // Divider next-state: restart from zero on disable or at the terminal count.
    always_comb begin
        div_d = div_q;
        if (!i_en) begin
            div_d = '0;
        end else if (div_q == LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + CW'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/updown_bcd_counter.sv
// Four-digit BCD up/down counter with run/stop, clear and direction commands.
// Define UPDOWN_SATURATE_EN to hold at 9999/0000 and auto-stop instead of wrapping.
module updown_bcd_counter
    import updown_bcd_counter_pkg::*;
#(
    parameter int SYS_CLK_HZ = DEF_SYS_CLK_HZ,
    parameter int TICK_HZ    = DEF_TICK_HZ,
    parameter int TICK_DIV   = SYS_CLK_HZ / TICK_HZ
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_run_stop,
    input  logic       i_clear,
    input  logic       i_mode,
    output logic [3:0] time_1,
    output logic [3:0] time_10,
    output logic [3:0] time_100,
    output logic [3:0] time_1000,
    output logic       o_running,
    output logic       o_down
);

    state_e          state_q;
    state_e          state_d;
    logic [3:0][3:0] dig_q;
    logic [3:0][3:0] dig_d;
    logic            running_q;
    logic            running_d;
    logic            down_q;
    logic            down_d;
    logic            tick_s;
    logic            at_limit_s;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (state_q == ST_RUN),
        .o_tick (tick_s)
    );

`ifdef UPDOWN_SATURATE_EN
    assign at_limit_s = down_q ? (dig_q == 16'h0000) : (dig_q == 16'h9999);
`else
    assign at_limit_s = 1'b0;
`endif

    // FSM next-state; clear overrides every other command.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (i_run_stop && !at_limit_s) state_d = ST_RUN;
                else                           state_d = ST_STOP;
            end
            ST_RUN: begin
                if (i_run_stop || at_limit_s) state_d = ST_STOP;
                else                          state_d = ST_RUN;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
        if (i_clear) begin
            state_d = ST_CLEAR;
        end else begin
            state_d = state_d;
        end
    end

    // Output/status next-state: direction toggles on every mode pulse regardless of state.
    always_comb begin
        running_d = (state_d == ST_RUN);
        down_d    = down_q ^ i_mode;
    end

    // Digit next-state: ripple carry/borrow from the ones digit upward on each tick.
    always_comb begin
        logic       carry;
        logic [4:0] step;
        dig_d = dig_q;
        carry = 1'b1;
        step  = 5'd0;
        if (i_clear || (state_q == ST_CLEAR)) begin
            dig_d = '0;
        end else if (tick_s && !at_limit_s) begin
            for (int i = 0; i < 4; i++) begin
                step     = bcd_step(dig_q[i], down_q, carry);
                dig_d[i] = step[3:0];
                carry    = step[4];
            end
        end else begin
            dig_d = dig_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_STOP;
            dig_q     <= '0;
            running_q <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            running_q <= running_d;
            down_q    <= down_d;
        end
    end

    assign time_1    = dig_q[0];
    assign time_10   = dig_q[1];
    assign time_100  = dig_q[2];
    assign time_1000 = dig_q[3];
    assign o_running = running_q;
    assign o_down    = down_q;

endmodule

// File: tb/tb_updown_bcd_counter.sv
// Directed self-checking bench for updown_bcd_counter with TICK_DIV = 4 (wrapping build).
module tb_updown_bcd_counter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_run_stop;
    logic       i_clear;
    logic       i_mode;
    logic [3:0] time_1;
    logic [3:0] time_10;
    logic [3:0] time_100;
    logic [3:0] time_1000;
    logic       o_running;
    logic       o_down;

    int passed = 0;
    int total  = 0;

    updown_bcd_counter #(
        .TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_run_stop (i_run_stop),
        .i_clear    (i_clear),
        .i_mode     (i_mode),
        .time_1     (time_1),
        .time_10    (time_10),
        .time_100   (time_100),
        .time_1000  (time_1000),
        .o_running  (o_running),
        .o_down     (o_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_all(input string tag, input logic [15:0] cnt, input logic run, input logic dn);
        check({tag, "_cnt"}, {time_1000, time_100, time_10, time_1}, cnt);
        check({tag, "_run"}, {15'd0, o_running}, {15'd0, run});
        check({tag, "_down"}, {15'd0, o_down}, {15'd0, dn});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic r, input logic c, input logic m);
        @(negedge clk);
        i_run_stop = r;
        i_clear    = c;
        i_mode     = m;
        @(negedge clk);
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_mode     = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn       = 1'b1;
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_mode     = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_all("reset", 16'h0000, 1'b0, 1'b0);
        cyc(2);
        rstn = 1'b1;
        cyc(1);
        check_all("post_reset", 16'h0000, 1'b0, 1'b0);

        // First tick TICK_DIV cycles after entering RUN, update one cycle later.
        pulse(1'b1, 1'b0, 1'b0);
        check_all("run_entry", 16'h0000, 1'b1, 1'b0);
        cyc(3);
        check("before_first_tick", {time_1000, time_100, time_10, time_1}, 16'h0000);
        cyc(1);
        check("first_inc", {time_1000, time_100, time_10, time_1}, 16'h0001);
        cyc(4);
        check("second_inc", {time_1000, time_100, time_10, time_1}, 16'h0002);
        cyc(388);
        check("reach_0099", {time_1000, time_100, time_10, time_1}, 16'h0099);
        cyc(4);
        check("carry_0100", {time_1000, time_100, time_10, time_1}, 16'h0100);

        // Stop when the divider holds 2, then re-run from a fresh period.
        cyc(1);
        pulse(1'b1, 1'b0, 1'b0);
        check_all("stop_mid", 16'h0100, 1'b0, 1'b0);
        cyc(10);
        check("frozen", {time_1000, time_100, time_10, time_1}, 16'h0100);
        pulse(1'b1, 1'b0, 1'b0);
        cyc(3);
        check("rerun_no_partial", {time_1000, time_100, time_10, time_1}, 16'h0100);
        cyc(1);
        check("rerun_inc", {time_1000, time_100, time_10, time_1}, 16'h0101);

        // Clear while running, then clear beating run/stop at 0042.
        pulse(1'b0, 1'b1, 1'b0);
        check_all("clear", 16'h0000, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        cyc(168);
        check_all("reach_0042", 16'h0042, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        check_all("clear_prio", 16'h0000, 1'b0, 1'b0);
        cyc(9);
        check_all("clear_then_stop", 16'h0000, 1'b0, 1'b0);

        // Down direction wraps 0000 -> 9999; flip up while running wraps 9999 -> 0000.
        pulse(1'b0, 1'b0, 1'b1);
        check_all("mode_down", 16'h0000, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        cyc(3);
        check("down_wait", {time_1000, time_100, time_10, time_1}, 16'h0000);
        cyc(1);
        check("down_wrap", {time_1000, time_100, time_10, time_1}, 16'h9999);
        cyc(4);
        check("down_9998", {time_1000, time_100, time_10, time_1}, 16'h9998);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("mode_up_no_change", 16'h9998, 1'b1, 1'b0);
        cyc(2);
        check("up_9999", {time_1000, time_100, time_10, time_1}, 16'h9999);
        cyc(4);
        check("up_wrap", {time_1000, time_100, time_10, time_1}, 16'h0000);

        // Borrow across three digits: 1000 -> 0999.
        cyc(4000);
        check("reach_1000", {time_1000, time_100, time_10, time_1}, 16'h1000);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("mode_down2", 16'h1000, 1'b1, 1'b1);
        cyc(2);
        check("borrow_0999", {time_1000, time_100, time_10, time_1}, 16'h0999);

        // Asynchronous reset between clock edges at 0357.
        cyc(2568);
        check_all("reach_0357", 16'h0357, 1'b1, 1'b1);
        #1 rstn = 1'b0;
        #1;
        check_all("async_reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        cyc(8);
        check_all("after_reset_idle", 16'h0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
